// File: rtl/cheri_branch_resolve_buffer.sv
// Multi-port branch/jump resolution classifier feeding an in-order FIFO to the frontend.
// Latency: 1 cycle enqueue-to-out_valid_o; ports stall on full FIFO, squash younger work after a mispredict.
module cheri_branch_resolve_buffer #(
  parameter int NrPorts   = 2,
  parameter int Depth     = 4,
  parameter int VLEN      = 64,
  parameter int MetaWidth = 64,
  parameter int CntWidth  = 32,
  localparam int MW       = (MetaWidth > 0) ? MetaWidth : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic [NrPorts-1:0]      in_valid_i,
  output logic [NrPorts-1:0]      in_ready_o,
  input  logic [NrPorts*VLEN-1:0] in_pc_i,
  input  logic [NrPorts*VLEN-1:0] in_target_i,
  input  logic [NrPorts*VLEN-1:0] in_next_pc_i,
  input  logic [NrPorts-1:0]      in_is_branch_i,
  input  logic [NrPorts-1:0]      in_is_jalr_i,
  input  logic [NrPorts-1:0]      in_taken_i,
  input  logic [NrPorts-1:0]      in_pred_taken_i,
  input  logic [NrPorts*VLEN-1:0] in_pred_addr_i,
  input  logic [NrPorts*MW-1:0]   in_target_meta_i,
  input  logic [NrPorts*MW-1:0]   in_pcc_meta_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [VLEN-1:0]         out_pc_o,
  output logic [VLEN-1:0]         out_target_o,
  output logic                    out_taken_o,
  output logic                    out_mispredict_o,
  output logic [CntWidth-1:0]     mispredict_cnt_o,
  output logic [CntWidth-1:0]     squash_cnt_o
);

  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);
  localparam int NW = $clog2(NrPorts + 1);

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target;
    logic            taken;
    logic            mispredict;
  } entry_t;

  typedef enum logic {S_RUN, S_DRAIN} state_e;

  state_e              r_state, w_state_nxt;
  entry_t              r_mem [Depth];
  logic [PW-1:0]       r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]       r_count;
  logic [CntWidth-1:0] r_mp_cnt, r_sq_cnt;

  logic [NrPorts-1:0]  w_mp, w_acc, w_sq;
  entry_t              w_ent [NrPorts];
  logic [PW-1:0]       w_off [NrPorts];
  logic [CW-1:0]       w_free, w_n_acc;
  logic [NW-1:0]       w_n_sq;
  logic                w_blocked, w_mp_lower, w_deq, w_meta_ne;
  logic [CntWidth:0]   w_sq_sum;

  always_comb begin
    w_mp      = '0;
    w_meta_ne = 1'b0;
    for (int i = 0; i < NrPorts; i++) begin
      w_meta_ne = (MetaWidth > 0) &&
                  (in_target_meta_i[i*MW +: MW] != in_pcc_meta_i[i*MW +: MW]);
      if (in_is_branch_i[i])
        w_mp[i] = in_taken_i[i] != in_pred_taken_i[i];
      else if (in_is_jalr_i[i])
        w_mp[i] = !in_pred_taken_i[i] ||
                  (in_target_i[i*VLEN +: VLEN] != in_pred_addr_i[i*VLEN +: VLEN]) ||
                  w_meta_ne;
      else
        w_mp[i] = in_taken_i[i] != in_pred_taken_i[i];
      w_ent[i].pc         = in_pc_i[i*VLEN +: VLEN];
      w_ent[i].target     = in_taken_i[i] ? in_target_i[i*VLEN +: VLEN]
                                          : in_next_pc_i[i*VLEN +: VLEN];
      w_ent[i].taken      = in_taken_i[i];
      w_ent[i].mispredict = w_mp[i];
    end
  end

  // Free space is taken from cycle-start occupancy: a same-cycle dequeue gives no credit.
  assign w_free = CW'(Depth) - r_count;

  always_comb begin
    w_acc      = '0;
    w_sq       = '0;
    w_n_acc    = '0;
    w_n_sq     = '0;
    w_blocked  = 1'b0;
    w_mp_lower = 1'b0;
    for (int i = 0; i < NrPorts; i++) begin
      w_off[i] = r_wr_ptr + PW'(w_n_acc);
      if (!flush_i && in_valid_i[i]) begin
        if (r_state == S_DRAIN || w_mp_lower) begin
          w_sq[i] = 1'b1;
          w_n_sq  = w_n_sq + NW'(1);
        end else if (!w_blocked && (w_free > w_n_acc)) begin
          w_acc[i]   = 1'b1;
          w_n_acc    = w_n_acc + CW'(1);
          w_mp_lower = w_mp[i];
        end else begin
          w_blocked = 1'b1;
        end
      end
    end
  end

  assign in_ready_o = w_acc | w_sq;
  assign w_deq      = (r_count != '0) && out_ready_i;

  // Only one mispredicted entry can be buffered, and it is always the youngest.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (|(w_acc & w_mp)) w_state_nxt = S_DRAIN;
        S_DRAIN: if (w_deq && r_mem[r_rd_ptr].mispredict) w_state_nxt = S_RUN;
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_RUN;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < Depth; k++) r_mem[k] <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < NrPorts; i++)
        if (w_acc[i]) r_mem[w_off[i]] <= w_ent[i];
      r_wr_ptr <= r_wr_ptr + PW'(w_n_acc);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count  <= r_count + w_n_acc - (w_deq ? CW'(1) : CW'(0));
    end
  end

  assign w_sq_sum = {1'b0, r_sq_cnt} + {{(CntWidth + 1 - NW){1'b0}}, w_n_sq};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mp_cnt <= '0;
      r_sq_cnt <= '0;
    end else if (!flush_i) begin
      if (w_deq && r_mem[r_rd_ptr].mispredict && !(&r_mp_cnt))
        r_mp_cnt <= r_mp_cnt + CntWidth'(1);
      r_sq_cnt <= w_sq_sum[CntWidth] ? {CntWidth{1'b1}} : w_sq_sum[CntWidth-1:0];
    end
  end

  assign out_valid_o      = (r_count != '0);
  assign out_pc_o         = r_mem[r_rd_ptr].pc;
  assign out_target_o     = r_mem[r_rd_ptr].target;
  assign out_taken_o      = r_mem[r_rd_ptr].taken;
  assign out_mispredict_o = r_mem[r_rd_ptr].mispredict;
  assign mispredict_cnt_o = r_mp_cnt;
  assign squash_cnt_o     = r_sq_cnt;

endmodule

// File: tb/tb_cheri_branch_resolve_buffer.sv
// Directed-vector bench: driver pushes expected head entries, monitor pops on each output handshake.
module tb_cheri_branch_resolve_buffer;
  localparam int NP = 2;
  localparam int VL = 64;
  localparam int MW = 64;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [NP-1:0]     in_valid = '0, in_ready;
  logic [NP*VL-1:0]  in_pc = '0, in_target = '0, in_next_pc = '0, in_pred_addr = '0;
  logic [NP-1:0]     in_is_branch = '0, in_is_jalr = '0, in_taken = '0, in_pred_taken = '0;
  logic [NP*MW-1:0]  in_target_meta = '0, in_pcc_meta = '0;
  logic              out_valid, out_ready = 1'b0, out_taken, out_mp;
  logic [VL-1:0]     out_pc, out_target;
  logic [CW-1:0]     mp_cnt, sq_cnt;

  cheri_branch_resolve_buffer #(
    .NrPorts(NP), .Depth(4), .VLEN(VL), .MetaWidth(MW), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_pc_i(in_pc), .in_target_i(in_target), .in_next_pc_i(in_next_pc),
    .in_is_branch_i(in_is_branch), .in_is_jalr_i(in_is_jalr),
    .in_taken_i(in_taken), .in_pred_taken_i(in_pred_taken),
    .in_pred_addr_i(in_pred_addr), .in_target_meta_i(in_target_meta),
    .in_pcc_meta_i(in_pcc_meta),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_target_o(out_target),
    .out_taken_o(out_taken), .out_mispredict_o(out_mp),
    .mispredict_cnt_o(mp_cnt), .squash_cnt_o(sq_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        tk;
    logic        mp;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] pc, input logic [63:0] tgt, input logic tk, input logic mp);
    exp_t e;
    e.pc = pc; e.tgt = tgt; e.tk = tk; e.mp = mp;
    q.push_back(e);
  endtask

  task automatic setp(input int p, input logic br, input logic jr, input logic tk, input logic pt,
                      input logic [63:0] pc, input logic [63:0] tgt, input logic [63:0] pa,
                      input logic [63:0] tm, input logic [63:0] pm);
    in_valid[p]              = 1'b1;
    in_is_branch[p]          = br;
    in_is_jalr[p]            = jr;
    in_taken[p]              = tk;
    in_pred_taken[p]         = pt;
    in_pc[p*VL +: VL]        = pc;
    in_target[p*VL +: VL]    = tgt;
    in_next_pc[p*VL +: VL]   = pc + 64'd4;
    in_pred_addr[p*VL +: VL] = pa;
    in_target_meta[p*MW +: MW] = tm;
    in_pcc_meta[p*MW +: MW]    = pm;
  endtask

  task automatic br(input int p, input logic tk, input logic pt, input logic [63:0] pc, input logic [63:0] tgt);
    setp(p, 1'b1, 1'b0, tk, pt, pc, tgt, tgt, 64'd0, 64'd0);
  endtask

  task automatic jalr(input int p, input logic [63:0] pc, input logic [63:0] tgt, input logic [63:0] pa,
                      input logic [63:0] tm, input logic [63:0] pm);
    setp(p, 1'b0, 1'b1, 1'b1, 1'b1, pc, tgt, pa, tm, pm);
  endtask

  // Inputs are held from posedge+1 to the next posedge; ready is checked at the negedge.
  task automatic step(input logic [1:0] exp_rdy, input string name);
    @(negedge clk);
    check(name, in_ready, exp_rdy);
    @(posedge clk);
    #1;
    in_valid = '0;
    flush    = 1'b0;
  endtask

  task automatic chk_cnt(input logic [CW-1:0] m, input logic [CW-1:0] s, input string name);
    check({name, "_mp_cnt"}, mp_cnt, m);
    check({name, "_sq_cnt"}, sq_cnt, s);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          vectors++;
          errs++;
          $display("FAIL unexpected_out: pc %0h delivered, none expected", out_pc);
        end else begin
          e = q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_target", out_target, e.tgt);
          check("out_taken", out_taken, e.tk);
          check("out_mispredict", out_mp, e.mp);
        end
      end
    end
  end

  initial begin : driver
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_target", out_target, 0);
    check("rst_out_flags", {out_taken, out_mp}, 0);
    check("rst_in_ready", in_ready, 0);
    chk_cnt(0, 0, "rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Correctly predicted taken branch, registered output
    br(0, 1, 1, 64'h100, 64'h1000);
    push(64'h100, 64'h1000, 1, 0);
    check("t1_no_bypass", out_valid, 0);
    step(2'b01, "t1_ready");
    check("t1_latency", out_valid, 1);
    step(2'b00, "t1_idle");
    chk_cnt(0, 0, "t1");

    // Not-taken branch predicted taken; younger port squashed; DRAIN until dequeue
    out_ready = 1'b0;
    br(0, 0, 1, 64'h200, 64'h2000);
    br(1, 1, 1, 64'h204, 64'h2040);
    push(64'h200, 64'h204, 0, 1);
    step(2'b11, "t2_mp_ready");
    chk_cnt(0, 1, "t2a");
    br(0, 1, 1, 64'h208, 64'h2080);
    step(2'b01, "t2_drain_sq");
    chk_cnt(0, 2, "t2b");
    out_ready = 1'b1;
    br(0, 1, 1, 64'h20C, 64'h20C0);
    step(2'b01, "t2_deq_sq");
    chk_cnt(1, 3, "t2c");

    // JALR with matching address but differing PCC metadata
    jalr(0, 64'h300, 64'h3000, 64'h3000, 64'hA, 64'hB);
    push(64'h300, 64'h3000, 1, 1);
    step(2'b01, "t3_meta_ready");
    step(2'b00, "t3_idle");
    chk_cnt(2, 3, "t3a");
    jalr(0, 64'h380, 64'h3800, 64'h3800, 64'h5, 64'h5);
    br(1, 0, 0, 64'h390, 64'h3900);
    push(64'h380, 64'h3800, 1, 0);
    push(64'h390, 64'h394, 0, 0);
    step(2'b11, "t3_ok_ready");
    step(2'b00, "t3_idle2");
    step(2'b00, "t3_idle3");
    chk_cnt(2, 3, "t3b");

    // Fill to Depth, then no same-cycle dequeue credit
    out_ready = 1'b0;
    br(0, 0, 0, 64'h400, 64'h4000); br(1, 0, 0, 64'h404, 64'h4040);
    push(64'h400, 64'h404, 0, 0); push(64'h404, 64'h408, 0, 0);
    step(2'b11, "t4_fill1");
    br(0, 0, 0, 64'h408, 64'h4080); br(1, 0, 0, 64'h40C, 64'h40C0);
    push(64'h408, 64'h40C, 0, 0); push(64'h40C, 64'h410, 0, 0);
    step(2'b11, "t4_fill2");
    out_ready = 1'b1;
    br(0, 0, 0, 64'h410, 64'h4100); br(1, 0, 0, 64'h414, 64'h4140);
    step(2'b00, "t4_full_no_credit");
    br(0, 0, 0, 64'h410, 64'h4100); br(1, 0, 0, 64'h414, 64'h4140);
    push(64'h410, 64'h414, 0, 0);
    step(2'b01, "t4_one_slot");
    br(1, 0, 0, 64'h414, 64'h4140);
    push(64'h414, 64'h418, 0, 0);
    step(2'b10, "t4_port1_only");

    // Flush with 3 buffered entries and valid inputs
    out_ready = 1'b0;
    flush = 1'b1;
    br(0, 0, 1, 64'h4F0, 64'h4F00); br(1, 1, 1, 64'h4F4, 64'h4F40);
    step(2'b00, "t5_flush_ready");
    q.delete();
    check("t5_out_valid", out_valid, 0);
    chk_cnt(2, 3, "t5a");
    out_ready = 1'b1;
    br(0, 1, 1, 64'h500, 64'h5000);
    push(64'h500, 64'h5000, 1, 0);
    step(2'b01, "t5_run_accept");
    chk_cnt(2, 3, "t5b");
    step(2'b00, "t5_idle");

    // Squash counter saturation while the mispredict waits at the head
    out_ready = 1'b0;
    br(0, 1, 0, 64'h600, 64'h6000); br(1, 1, 1, 64'h604, 64'h6040);
    push(64'h600, 64'h6000, 1, 1);
    step(2'b11, "t6_mp");
    chk_cnt(2, 4, "t6_base");
    for (int n = 1; n <= 8; n++) begin
      br(0, 1, 1, 64'h610, 64'h6100); br(1, 1, 1, 64'h614, 64'h6140);
      step(2'b11, "t6_sq_ready");
      k = 4 + 2 * n;
      chk_cnt(2, (k > 15) ? 4'hF : k[3:0], "t6_sat");
    end
    out_ready = 1'b1;
    step(2'b00, "t6_release");
    chk_cnt(3, 15, "t6_end");

    for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
    #1;
    check("scoreboard_empty", q.size(), 0);

    // Reset mid-operation discards buffered entry and clears counters
    out_ready = 1'b0;
    br(0, 1, 1, 64'h700, 64'h7000);
    step(2'b01, "t7_enq");
    check("t7_valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t7_out_valid", out_valid, 0);
    check("t7_out_pc", out_pc, 0);
    chk_cnt(0, 0, "t7");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/cheri_branch_resolve_buffer.md
Name: cheri_branch_resolve_buffer

Overview:
Multi-port successor to the single-issue branch unit. Accepts up to NrPorts branch/jump resolutions per cycle and classifies each as mispredicted or not, including the CHERI case where PCC metadata changes. Results are buffered in order in a Depth-entry FIFO and drained to the frontend over a valid/ready handshake. After a mispredict, younger resolutions are squashed until the mispredicting entry has been delivered.

Parameters:
NrPorts, 2, number of parallel resolution input ports; port 0 is oldest in program order.
Depth, 4, FIFO entries; power of two, must be >= NrPorts.
VLEN, 64, address width of pc, target and predicted address.
MetaWidth, 64, PCC metadata width (CLEN-XLEN); 0 disables the metadata compare.
CntWidth, 32, width of the statistics counters.

Ports:
clk_i  in  1  subsystem clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  commit-side flush; empties buffer
in_valid_i  in  NrPorts  resolution valid per port
in_ready_o  out  NrPorts  port accepted this cycle
in_pc_i  in  NrPorts*VLEN  instruction PC
in_target_i  in  NrPorts*VLEN  computed target
in_next_pc_i  in  NrPorts*VLEN  fall-through PC
in_is_branch_i  in  NrPorts  conditional branch
in_is_jalr_i  in  NrPorts  register jump (JALR/CJALR)
in_taken_i  in  NrPorts  ALU compare result (1 for jumps)
in_pred_taken_i  in  NrPorts  predictor said taken
in_pred_addr_i  in  NrPorts*VLEN  predicted target
in_target_meta_i  in  NrPorts*MetaWidth  target PCC metadata
in_pcc_meta_i  in  NrPorts*MetaWidth  current PCC metadata
out_valid_o  out  1  head entry valid
out_ready_i  in  1  frontend consumes head
out_pc_o  out  VLEN  head PC
out_target_o  out  VLEN  resolved address (target if taken, else next_pc)
out_taken_o  out  1  head taken
out_mispredict_o  out  1  head mispredicted
mispredict_cnt_o  out  CntWidth  saturating count of delivered mispredicts
squash_cnt_o  out  CntWidth  saturating count of dropped resolutions

Behaviour:
- Mispredict at enqueue:
  - Branch: taken != pred_taken.
  - JALR: !pred_taken, or target != pred_addr, or (MetaWidth>0 and target_meta != pcc_meta).
  - Neither: taken != pred_taken.
- State RUN:
  - Port i is accepted iff in_valid_i[i], all lower valid ports are accepted, free slots (measured at cycle start, no same-cycle dequeue credit) > number of lower accepted ports, and no lower port accepted this cycle is mispredicted.
  - Accepted entries are written in port order.
  - A valid port not accepted because an older port mispredicted is squashed: it counts in squash_cnt_o and in_ready_o is high.
  - A port refused only for lack of space keeps in_ready_o low; upstream holds it.
  - If any accepted entry is mispredicted, next state is DRAIN.
- State DRAIN:
  - All valid inputs are squashed (in_ready_o=in_valid_i) and counted.
  - Returns to RUN the cycle after the mispredicted entry is dequeued.
  - Inputs in that dequeue cycle are still squashed.
- Output side:
  - Registered; no bypass. Earliest out_valid_o is the cycle after enqueue.
  - Dequeue occurs when out_valid_o && out_ready_i.
  - Output fields are stable while out_valid_o && !out_ready_i.
- Pointers: read/write pointers wrap modulo Depth; count ranges 0..Depth. Enqueue and dequeue in the same cycle are permitted.
- Counters:
  - mispredict_cnt_o increments on dequeue of a mispredicted entry.
  - squash_cnt_o adds the number of squashed ports per cycle.
  - Both saturate at all-ones and are not cleared by flush_i.
- flush_i: highest priority. Next cycle count=0, state RUN, out_valid_o=0. Inputs in the flush cycle are neither enqueued nor counted; in_ready_o=0.
- Reset: count=0, pointers=0, RUN, out_valid_o=0, all out_* fields 0, counters 0. Reset mid-operation discards all entries.

Test Plan:
1. Reset, then port0 branch taken=1 pred=1 target 0x1000 -> out_valid_o next cycle, out_target_o=0x1000, mispredict=0; cnt stays 0.
2. Same cycle port0 branch taken=0 pred=1, port1 valid -> port0 enqueued mispredict=1 with target=next_pc; port1 squashed, squash_cnt=1; DRAIN until dequeue.
3. JALR with target==pred_addr but target_meta=0xA != pcc_meta=0xB -> mispredict=1.
4. Depth=4 full, out_ready_i=1, two valid inputs -> both in_ready_o=0 (no credit); next cycle count=3 and port0 accepted.
5. flush_i asserted with 3 entries and inputs valid -> next cycle out_valid_o=0, in_ready_o=0 in flush cycle, state RUN, counters unchanged.
6. Hold out_ready_i=0 for 2^CntWidth squash events (use CntWidth=4) -> squash_cnt_o saturates at 0xF.
